if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers the returned word with its PC and PC+4 for IF/ID.
- Honours hazard-unit stalls and branch/jump redirects from later stages.

---
 rtl/if_fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the pipelined MIPS core. Owns the PC, issues one
// request at a time to a variable-latency instruction memory, and presents the
// returned word together with its PC and PC+4 to the IF/ID register. A one-entry
// skid register catches a response that arrives while IF/ID is stalled with a
// full output buffer. Redirects from later stages squash everything in flight.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall_i        IF/ID will not capture this cycle
//   redirect_i     branch/jump taken (single-cycle pulse)
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_req_o     fetch request, high for exactly one cycle per request
//   imem_addr_o    word-aligned fetch address, valid with imem_req_o
//   imem_rvalid_i  instruction memory response valid
//   imem_rdata_i   instruction word, valid with imem_rvalid_i
//   valid_o        output buffer holds a real instruction
//   instruction_o  fetched instruction, NOP_INSTR when valid_o=0
//   pc_now_o       address of instruction_o
//   pc_next4_o     pc_now_o + 4
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_now_o,
    output logic [31:0] pc_next4_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        drop_r;          // the outstanding response belongs to a squashed request
    logic        skid_valid_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;
    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] pc_now_r;
    logic [31:0] pc_next4_r;
    logic        req_r;
    logic [31:0] addr_r;

    logic        consume_s;
    logic [31:0] pc_inc_s;
    logic [31:0] redirect_pc_s;

    // PC arithmetic wraps modulo 2^32 by construction of the 32-bit adder.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    assign consume_s     = valid_r & ~stall_i;
    assign pc_inc_s      = pc_plus4(pc_r);
    assign redirect_pc_s = {redirect_pc_i[31:2], 2'b00};

    // Fetch FSM, output buffer and skid register. imem_req_o/imem_addr_o are
    // registered: they are set on the edge that enters FETCH, with the address
    // that pc_r takes on that same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            drop_r       <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            valid_r      <= 1'b0;
            instr_r      <= NOP_INSTR;
            pc_now_r     <= 32'h0000_0000;
            pc_next4_r   <= 32'h0000_0000;
            req_r        <= 1'b0;
            addr_r       <= 32'h0000_0000;
        end else begin
            req_r <= 1'b0;
            // Downstream takes the buffered word; later loads on this edge override.
            if (consume_s) begin
                valid_r <= 1'b0;
                instr_r <= NOP_INSTR;
            end
            if (redirect_i) begin
                pc_r         <= redirect_pc_s;
                valid_r      <= 1'b0;
                instr_r      <= NOP_INSTR;
                skid_valid_r <= 1'b0;
                case (state_r)
                    FETCH: begin
                        // The request leaving this cycle still gets a response.
                        drop_r  <= 1'b1;
                        state_r <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid_i) begin
                            drop_r  <= 1'b0;
                            state_r <= FETCH;
                            req_r   <= 1'b1;
                            addr_r  <= redirect_pc_s;
                        end else begin
                            drop_r  <= 1'b1;
                        end
                    end
                    default: begin
                        drop_r  <= 1'b0;
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                        addr_r  <= redirect_pc_s;
                    end
                endcase
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                        addr_r  <= pc_r;
                    end
                    FETCH: begin
                        state_r <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid_i && drop_r) begin
                            drop_r  <= 1'b0;
                            state_r <= FETCH;
                            req_r   <= 1'b1;
                            addr_r  <= pc_r;
                        end else if (imem_rvalid_i && (!valid_r || consume_s)) begin
                            valid_r    <= 1'b1;
                            instr_r    <= imem_rdata_i;
                            pc_now_r   <= pc_r;
                            pc_next4_r <= pc_inc_s;
                            pc_r       <= pc_inc_s;
                            state_r    <= FETCH;
                            req_r      <= 1'b1;
                            addr_r     <= pc_inc_s;
                        end else if (imem_rvalid_i) begin
                            // Buffer full and stalled: park the word.
                            skid_valid_r <= 1'b1;
                            skid_instr_r <= imem_rdata_i;
                            skid_pc_r    <= pc_r;
                            pc_r         <= pc_inc_s;
                            state_r      <= HOLD;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            valid_r      <= 1'b1;
                            instr_r      <= skid_instr_r;
                            pc_now_r     <= skid_pc_r;
                            pc_next4_r   <= pc_plus4(skid_pc_r);
                            skid_valid_r <= 1'b0;
                            state_r      <= FETCH;
                            req_r        <= 1'b1;
                            addr_r       <= pc_r;
                        end else begin
                            state_r <= HOLD;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_req_o    = req_r;
    assign imem_addr_o   = addr_r;
    assign valid_o       = valid_r;
    assign instruction_o = instr_r;
    assign pc_now_o      = pc_now_r;
    assign pc_next4_o    = pc_next4_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        req1, rvalid1, valid1;
    logic [31:0] addr1, rdata1, instr1, pcn1, pc41;
    logic        req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, instr2, pcn2, pc42;

    int checks = 0;
    int errors = 0;

    logic [1:0]  lat;
    logic [1:0]  cnt;
    logic [31:0] saved_addr;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_rvalid_i(rvalid1), .imem_rdata_i(rdata1), .valid_o(valid1),
        .instruction_o(instr1), .pc_now_o(pcn1), .pc_next4_o(pc41)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2), .valid_o(valid2),
        .instruction_o(instr2), .pc_now_o(pcn2), .pc_next4_o(pc42)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : {16'hC0DE, a[15:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Variable-latency memory for dut: response lat cycles after the request.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 2'd0;
            saved_addr <= 32'h0;
        end else if (req1) begin
            cnt        <= lat;
            saved_addr <= addr1;
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end
    assign rvalid1 = (cnt == 2'd1);
    assign rdata1  = rvalid1 ? word(saved_addr) : 32'h0;

    // One-cycle memory for dut_wrap.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid2 <= 1'b0;
            rdata2  <= 32'h0;
        end else begin
            rvalid2 <= req2;
            rdata2  <= word(addr2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] l);
        reset      = 1'b0;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        lat        = l;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        lat           = 2'd1;
        step(2);
        chk("rst_valid", {31'b0, valid1}, 32'h0);
        chk("rst_instr", instr1, 32'h0);
        chk("rst_pcnow", pcn1, 32'h0);
        chk("rst_pc4",   pc41, 32'h0);
        chk("rst_req",   {31'b0, req1}, 32'h0);

        // First fetch and free-run with 1-cycle memory.
        reset = 1'b1;
        chk("rel_req", {31'b0, req1}, 32'h0);
        step(1);
        chk("f1_req",  {31'b0, req1}, 32'h1);
        chk("f1_addr", addr1, 32'h0);
        step(1);
        chk("f2_req",  {31'b0, req1}, 32'h0);
        step(1);
        chk("f3_valid", {31'b0, valid1}, 32'h1);
        chk("f3_instr", instr1, 32'h2008_0005);
        chk("f3_pcnow", pcn1, 32'h0);
        chk("f3_pc4",   pc41, 32'h4);
        chk("f3_addr",  addr1, 32'h4);
        step(1);
        chk("f4_valid", {31'b0, valid1}, 32'h0);
        chk("f4_instr", instr1, 32'h0);
        step(1);
        chk("f5_pcnow", pcn1, 32'h4);
        chk("f5_instr", instr1, 32'hC0DE_0004);
        chk("f5_addr",  addr1, 32'h8);
        step(2);
        chk("f7_pcnow", pcn1, 32'h8);
        chk("f7_addr",  addr1, 32'hC);
        step(2);
        chk("f9_pcnow", pcn1, 32'hC);
        chk("f9_pc4",   pc41, 32'h10);
        chk("f9_addr",  addr1, 32'h10);

        // Stall with full buffer and a response arriving -> HOLD.
        do_reset(2'd1);
        step(5);
        chk("s5_pcnow", pcn1, 32'h4);
        stall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("s_valid", {31'b0, valid1}, 32'h1);
            chk("s_pcnow", pcn1, 32'h4);
            chk("s_instr", instr1, 32'hC0DE_0004);
            chk("s_req",   {31'b0, req1}, 32'h0);
        end
        stall_i = 1'b0;
        step(1);
        chk("h_valid", {31'b0, valid1}, 32'h1);
        chk("h_pcnow", pcn1, 32'h8);
        chk("h_instr", instr1, 32'hC0DE_0008);
        chk("h_pc4",   pc41, 32'hC);
        chk("h_req",   {31'b0, req1}, 32'h1);
        chk("h_addr",  addr1, 32'hC);
        step(1);
        chk("h2_valid", {31'b0, valid1}, 32'h0);
        step(1);
        chk("h3_pcnow", pcn1, 32'hC);
        chk("h3_valid", {31'b0, valid1}, 32'h1);

        // Redirect while waiting on a 3-cycle memory.
        do_reset(2'd3);
        step(2);
        chk("r2_req", {31'b0, req1}, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0042;
        step(1);
        redirect_i = 1'b0;
        chk("r3_valid", {31'b0, valid1}, 32'h0);
        step(2);
        chk("r5_req",   {31'b0, req1}, 32'h1);
        chk("r5_addr",  addr1, 32'h40);
        chk("r5_valid", {31'b0, valid1}, 32'h0);
        step(4);
        chk("r9_valid", {31'b0, valid1}, 32'h1);
        chk("r9_pcnow", pcn1, 32'h40);
        chk("r9_pc4",   pc41, 32'h44);
        chk("r9_instr", instr1, 32'hC0DE_0040);

        // Redirect and stall together with a full buffer.
        do_reset(2'd1);
        step(3);
        chk("rs3_valid", {31'b0, valid1}, 32'h1);
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        step(1);
        chk("rs4_valid", {31'b0, valid1}, 32'h0);
        chk("rs4_instr", instr1, 32'h0);
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        step(1);
        chk("rs5_req",  {31'b0, req1}, 32'h1);
        chk("rs5_addr", addr1, 32'h100);
        step(2);
        chk("rs7_pcnow", pcn1, 32'h100);
        chk("rs7_instr", instr1, 32'hC0DE_0100);

        // PC wrap-around from RESET_PC = FFFF_FFFC.
        do_reset(2'd1);
        step(1);
        chk("w1_req",  {31'b0, req2}, 32'h1);
        chk("w1_addr", addr2, 32'hFFFF_FFFC);
        step(2);
        chk("w3_valid", {31'b0, valid2}, 32'h1);
        chk("w3_pcnow", pcn2, 32'hFFFF_FFFC);
        chk("w3_pc4",   pc42, 32'h0);
        chk("w3_instr", instr2, 32'hC0DE_FFFC);
        chk("w3_addr",  addr2, 32'h0);

        // Reset asserted mid-WAIT with a held instruction.
        do_reset(2'd1);
        step(3);
        stall_i = 1'b1;
        step(1);
        chk("m4_valid", {31'b0, valid1}, 32'h1);
        reset = 1'b0;
        #1;
        chk("m_valid", {31'b0, valid1}, 32'h0);
        chk("m_instr", instr1, 32'h0);
        chk("m_pcnow", pcn1, 32'h0);
        chk("m_pc4",   pc41, 32'h0);
        chk("m_req",   {31'b0, req1}, 32'h0);
        step(1);
        reset   = 1'b1;
        stall_i = 1'b0;
        step(1);
        chk("m_req2",  {31'b0, req1}, 32'h1);
        chk("m_addr2", addr1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
